ws2812_chain: RTL and testbench
===============================

WS2812_CHAIN -- requirements
Module: ws2812_chain

Interface
REQ-001 SHALL have parameter CLK_SPEED, default 27_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter NUM_LEDS, default 64, number of pixels in the chain, range 1..1024.
REQ-003 SHALL have parameter RES_US, default 50, latch (reset-code) low time in microseconds.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1 bit: pixel RAM write strobe.
REQ-007 SHALL have port wr_addr, input, $clog2(NUM_LEDS) bits (minimum 1): pixel index.
REQ-008 SHALL have port wr_rgb, input, 24 bits: {r,g,b} write data.
REQ-009 SHALL have port start, input, 1 bit: request one frame transmission.
REQ-010 SHALL have port auto_refresh, input, 1 bit: when 1, restart a frame after each latch.
REQ-011 SHALL have port busy, output, 1 bit: a frame or latch is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of the latch period.
REQ-013 SHALL have port ws2812_o, output, 1 bit: serial data line.

Function
REQ-014 SHALL derive T_LONG = CLK_SPEED*8/10_000_000, T_SHORT = CLK_SPEED*4/10_000_000 and T_RES = CLK_SPEED/1_000_000*RES_US in integer arithmetic; at 27 MHz: 21, 10, 1350.
REQ-015 SHALL hold NUM_LEDS x 24-bit pixel RAM: synchronous write on wr_en; wr_addr >= NUM_LEDS ignored.
REQ-016 SHALL implement states IDLE, LOAD, HIGH, LOW, LATCH.
REQ-017 IDLE: ws2812_o=0, busy=0; start=1 -> LOAD with pixel index 0.
REQ-018 LOAD: one-cycle synchronous RAM read of the current pixel; reorder to GRB, MSB first; -> HIGH.
REQ-019 HIGH: ws2812_o=1 for T_LONG cycles if the current bit is 1, else T_SHORT; -> LOW.
REQ-020 LOW: ws2812_o=0 for T_SHORT cycles if the current bit is 1, else T_LONG; then next bit -> HIGH, or after bit 23 next pixel -> LOAD, or after the last pixel -> LATCH.
REQ-021 The inter-pixel LOAD cycle SHALL be absorbed by ending LOW one cycle early, so every bit period is exactly T_LONG+T_SHORT cycles.
REQ-022 LATCH: ws2812_o=0 for T_RES cycles; then done=1 for one cycle; -> LOAD (pixel 0) if auto_refresh=1 or start was seen during busy, else -> IDLE.
REQ-023 start while busy SHALL set one pending flag (not counted); the flag clears when the next frame begins.
REQ-024 Writes during transmission SHALL be permitted; a pixel's value is the RAM content at its LOAD cycle, and same-cycle write/read of one address returns old data.
REQ-025 busy SHALL be 1 in LOAD, HIGH, LOW and LATCH.
REQ-026 First rising edge of ws2812_o SHALL appear 2 cycles after the start cycle (IDLE->LOAD->HIGH).
REQ-027 Counters SHALL be 16 bits wide and wide enough for T_RES; elaboration SHALL fail if T_SHORT < 2 or T_RES >= 65536.

Reset
REQ-028 rst SHALL force IDLE, ws2812_o=0, busy=0, done=0, pending=0, counters=0 on the next edge, including mid-frame.
REQ-029 rst SHALL NOT clear pixel RAM contents.

Structure
REQ-030 SHALL place timing-derivation functions and the state enum in package ws2812_pkg.
REQ-031 SHALL instantiate a single sub-module ws2812_pixram (parametrised depth, 24-bit width, one write port, one synchronous read port).

Verification
REQ-032 27 MHz, NUM_LEDS=2, pixel0=FF0000, pixel1=000001, start -> 48 bits decoded as G,R,B per pixel; '1' high 21 / low 10 cycles, '0' high 10 / low 21; period 31 throughout.
REQ-033 After the last bit -> ws2812_o low 1350 cycles, done pulse, busy falls on the following cycle.
REQ-034 start pulsed 3 times mid-frame, auto_refresh=0 -> exactly one extra frame, then IDLE.
REQ-035 auto_refresh=1 with pixel0 rewritten during frame 1 -> frame 2 carries the new value; frames are separated by exactly 1350 low cycles.
REQ-036 rst asserted in HIGH of bit 5 -> ws2812_o=0 and busy=0 next cycle; a new start replays the frame with RAM intact.
REQ-037 wr_addr=NUM_LEDS with wr_en=1 -> no RAM change; the frame is unchanged.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg
//   Shared definitions for the WS2812 chain driver: the transmitter state
//   encoding, counter/pixel widths, and the functions that turn a clock
//   frequency into the bit and reset-code cycle counts.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_t;

  localparam int CNT_W  = 16;
  localparam int PIX_W  = 24;
  localparam int BIT_W  = 5;

  // 0.8 us "long" half of a bit period, in clock cycles.
  function automatic int t_long_f(input longint clk_hz);
    return int'(clk_hz * 8 / 10_000_000);
  endfunction

  // 0.4 us "short" half of a bit period, in clock cycles.
  function automatic int t_short_f(input longint clk_hz);
    return int'(clk_hz * 4 / 10_000_000);
  endfunction

  // Reset-code low time; the divide happens first so the result matches
  // the whole-cycles-per-microsecond figure the strip timing is built on.
  function automatic int t_res_f(input longint clk_hz, input longint res_us);
    return int'(clk_hz / 1_000_000 * res_us);
  endfunction

endpackage

// File: rtl/ws2812_pixram.sv
// ws2812_pixram
//   Pixel storage: DEPTH words of WIDTH bits, one write port and one
//   registered read port. Read-before-write: a read and a write of the same
//   address in one cycle returns the old word. Writes to addresses at or
//   beyond DEPTH are dropped. Contents are never reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates only when set
//   rd_addr  in   read address
//   rd_data  out  registered read data
module ws2812_pixram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 24
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ws2812_chain.sv
// ws2812_chain
//   Drives a chain of WS2812 pixels from an internal pixel RAM. Each pixel is
//   sent as 24 bits in G,R,B order, MSB first; every bit period is
//   T_LONG+T_SHORT cycles, followed after the last pixel by a T_RES-cycle
//   low reset code that latches the strip.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset (pixel RAM unaffected)
//   wr_en         in   pixel RAM write strobe
//   wr_addr       in   pixel index to write
//   wr_rgb        in   {r,g,b} pixel value
//   start         in   request a frame; while busy, queues exactly one more
//   auto_refresh  in   restart a frame after every reset code
//   busy          out  frame or reset code in progress
//   done          out  one-cycle pulse in the final reset-code cycle
//   ws2812_o      out  serial data line
module ws2812_chain
  import ws2812_pkg::*;
#(
  parameter int CLK_SPEED = 27_000_000,
  parameter int NUM_LEDS  = 64,
  parameter int RES_US    = 50,
  localparam int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_rgb,
  input  logic              start,
  input  logic              auto_refresh,
  output logic              busy,
  output logic              done,
  output logic              ws2812_o
);

  localparam int T_LONG  = t_long_f(CLK_SPEED);
  localparam int T_SHORT = t_short_f(CLK_SPEED);
  localparam int T_RES   = t_res_f(CLK_SPEED, RES_US);

  // The inter-pixel LOAD steals a cycle from LOW, so T_SHORT must leave at
  // least one LOW cycle; the reset code must fit the 16-bit counter.
  if (T_SHORT < 2 || T_RES >= 65536 || T_RES < 1) begin : g_bad_timing
    $error("ws2812_chain: unusable timing for CLK_SPEED/RES_US");
  end
  if (NUM_LEDS < 1 || NUM_LEDS > 1024) begin : g_bad_depth
    $error("ws2812_chain: NUM_LEDS out of range 1..1024");
  end

  localparam logic [CNT_W-1:0]  T_LONG_C  = CNT_W'(T_LONG);
  localparam logic [CNT_W-1:0]  T_SHORT_C = CNT_W'(T_SHORT);
  localparam logic [CNT_W-1:0]  T_RES_C   = CNT_W'(T_RES);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] PIX_ONE   = ADDR_W'(1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(PIX_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              pend_q, pend_d;

  logic [PIX_W-1:0]  rd_rgb;
  logic [PIX_W-1:0]  grb;
  logic              cur_bit;
  logic              last_bit;
  logic              last_pix;
  logic [CNT_W-1:0]  hi_len;
  logic [CNT_W-1:0]  lo_len;
  logic [CNT_W-1:0]  lo_len_eff;

  ws2812_pixram #(
    .DEPTH  (NUM_LEDS),
    .ADDR_W (ADDR_W),
    .WIDTH  (PIX_W)
  ) u_pixram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_rgb),
    .rd_en   (state_q == ST_LOAD),
    .rd_addr (pix_q),
    .rd_data (rd_rgb)
  );

  // rd_rgb holds the pixel captured in its LOAD cycle for all 24 bits, so
  // later RAM writes cannot disturb a pixel already on the wire.
  assign grb      = {rd_rgb[15:8], rd_rgb[23:16], rd_rgb[7:0]};
  assign cur_bit  = grb[LAST_BIT - bit_q];
  assign last_bit = (bit_q == LAST_BIT);
  assign last_pix = (pix_q == LAST_PIX);

  assign hi_len     = cur_bit ? T_LONG_C  : T_SHORT_C;
  assign lo_len     = cur_bit ? T_SHORT_C : T_LONG_C;
  // Shorten the last LOW of a pixel by one so the following LOAD cycle
  // completes the bit period.
  assign lo_len_eff = (last_bit && !last_pix) ? (lo_len - 16'd1) : lo_len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    pix_d   = pix_q;
    pend_d  = pend_q;

    if (start && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_LOAD;
          pix_d   = '0;
          bit_d   = '0;
        end
      end

      ST_LOAD: begin
        state_d = ST_HIGH;
        cnt_d   = '0;
        bit_d   = '0;
      end

      ST_HIGH: begin
        if (cnt_q == hi_len - 16'd1) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end

      ST_LOW: begin
        if (cnt_q == lo_len_eff - 16'd1) begin
          cnt_d = '0;
          if (!last_bit) begin
            state_d = ST_HIGH;
            bit_d   = bit_q + 5'd1;
          end else if (!last_pix) begin
            state_d = ST_LOAD;
            pix_d   = pix_q + PIX_ONE;
            bit_d   = '0;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end

      ST_LATCH: begin
        if (cnt_q == T_RES_C - 16'd1) begin
          cnt_d = '0;
          // A start arriving in this very cycle also counts as a queued
          // request; the flag is consumed as the new frame begins.
          if (auto_refresh || pend_q || start) begin
            state_d = ST_LOAD;
            pix_d   = '0;
            bit_d   = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      pend_q  <= pend_d;
    end
  end

  assign ws2812_o = (state_q == ST_HIGH);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_LATCH) && (cnt_q == T_RES_C - 16'd1);

endmodule

// File: tb/tb_ws2812_chain.sv
// tb_ws2812_chain
//   Directed bench for ws2812_chain at 27 MHz. Instance a has two pixels,
//   instance b has three (so an address equal to NUM_LEDS is expressible).
//   The serial line is decoded back into bits by pulse width.
module tb_ws2812_chain;

  localparam int T_LONG  = 21;
  localparam int T_SHORT = 10;
  localparam int T_RES   = 1350;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        wr_en_a = 1'b0;
  logic [0:0]  wr_addr_a = '0;
  logic [23:0] wr_rgb_a = '0;
  logic        start_a = 1'b0;
  logic        auto_a = 1'b0;
  logic        busy_a, done_a, ws_a;

  logic        wr_en_b = 1'b0;
  logic [1:0]  wr_addr_b = '0;
  logic [23:0] wr_rgb_b = '0;
  logic        start_b = 1'b0;
  logic        auto_b = 1'b0;
  logic        busy_b, done_b, ws_b;

  logic        sel = 1'b0;
  wire         line   = sel ? ws_b   : ws_a;
  wire         done_s = sel ? done_b : done_a;
  wire         busy_s = sel ? busy_b : busy_a;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ws2812_chain #(.CLK_SPEED(27_000_000), .NUM_LEDS(2), .RES_US(50)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en_a),
    .wr_addr      (wr_addr_a),
    .wr_rgb       (wr_rgb_a),
    .start        (start_a),
    .auto_refresh (auto_a),
    .busy         (busy_a),
    .done         (done_a),
    .ws2812_o     (ws_a)
  );

  ws2812_chain #(.CLK_SPEED(27_000_000), .NUM_LEDS(3), .RES_US(50)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en_b),
    .wr_addr      (wr_addr_b),
    .wr_rgb       (wr_rgb_b),
    .start        (start_b),
    .auto_refresh (auto_b),
    .busy         (busy_b),
    .done         (done_b),
    .ws2812_o     (ws_b)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_px(input bit b, input int addr, input logic [23:0] rgb);
    @(posedge clk); #1;
    if (b) begin
      wr_en_b = 1'b1; wr_addr_b = 2'(addr); wr_rgb_b = rgb;
    end else begin
      wr_en_a = 1'b1; wr_addr_a = 1'(addr); wr_rgb_a = rgb;
    end
    @(posedge clk); #1;
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Decode one frame. lat = negedge samples until the line first goes high;
  // last_lo = low samples after the final bit up to and including done.
  // Returns at the negedge where done is seen.
  task automatic get_frame(input int nbits, output logic [71:0] data,
                           output int lat, output int bad, output int last_lo);
    int hi;
    int lo;
    data = '0; lat = 0; bad = 0; last_lo = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!line && lat < 5000);
    if (!line) begin
      check("frame_start", 72'(line), 72'd1);
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      hi = 0;
      while (line && hi < 100) begin hi++; @(negedge clk); end
      lo = 0;
      if (b == nbits - 1) begin
        while (!done_s && lo < 5000) begin lo++; @(negedge clk); end
        lo++;
        last_lo = lo;
        data = {data[70:0], (hi == T_LONG)};
        if (hi != T_LONG && hi != T_SHORT) bad++;
      end else begin
        while (!line && lo < 100) begin lo++; @(negedge clk); end
        if (hi == T_LONG && lo == T_SHORT)      data = {data[70:0], 1'b1};
        else if (hi == T_SHORT && lo == T_LONG) data = {data[70:0], 1'b0};
        else begin data = {data[70:0], 1'b0}; bad++; end
      end
    end
  endtask

  initial begin
    logic [71:0] d;
    int lat, bad, llo, rises, n;
    logic prev;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ws", 72'(ws_a), 72'd0);
    check("rst_busy", 72'(busy_a), 72'd0);
    check("rst_done", 72'(done_a), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic two-pixel frame: GRB stream 00 FF 00 | 00 00 01
    write_px(0, 0, 24'hFF0000);
    write_px(0, 1, 24'h000001);
    pulse_start(0);
    get_frame(48, d, lat, bad, llo);
    check("f1_latency", 72'(lat), 72'd2);
    check("f1_data", d, 72'h00FF00_000001);
    check("f1_timing", 72'(bad), 72'd0);
    check("f1_latch_len", 72'(llo), 72'(T_SHORT + T_RES));
    check("f1_done_busy", 72'(busy_a), 72'd1);
    @(negedge clk);
    check("f1_busy_fall", 72'(busy_a), 72'd0);
    check("f1_done_pulse", 72'(done_a), 72'd0);

    // Three starts mid-frame queue exactly one extra frame
    pulse_start(0);
    fork
      get_frame(48, d, lat, bad, llo);
      begin
        repeat (300) @(posedge clk);
        repeat (3) begin
          pulse_start(0);
          repeat (50) @(posedge clk);
        end
      end
    join
    check("q1_data", d, 72'h00FF00_000001);
    get_frame(48, d, lat, bad, llo);
    check("q2_latency", 72'(lat), 72'd2);
    check("q2_data", d, 72'h00FF00_000001);
    check("q2_timing", 72'(bad), 72'd0);
    @(negedge clk);
    check("q2_busy_fall", 72'(busy_a), 72'd0);
    repeat (200) @(negedge clk);
    check("q_idle_busy", 72'(busy_a), 72'd0);
    check("q_idle_line", 72'(ws_a), 72'd0);

    // Auto refresh; pixel 0 rewritten after it was loaded in frame 1
    auto_a = 1'b1;
    pulse_start(0);
    fork
      get_frame(48, d, lat, bad, llo);
      begin
        repeat (500) @(posedge clk);
        write_px(0, 0, 24'h123456);
      end
    join
    check("a1_data", d, 72'h00FF00_000001);
    check("a1_latch_len", 72'(llo), 72'(T_SHORT + T_RES));
    fork
      get_frame(48, d, lat, bad, llo);
      begin
        repeat (300) @(posedge clk);
        #1 auto_a = 1'b0;
      end
    join
    check("a2_latency", 72'(lat), 72'd2);
    check("a2_data", d, 72'h341256_000001);
    check("a2_timing", 72'(bad), 72'd0);
    check("a2_latch_len", 72'(llo), 72'(T_SHORT + T_RES));
    @(negedge clk);
    check("a2_busy_fall", 72'(busy_a), 72'd0);

    // Reset during HIGH of bit 5, then replay from intact RAM
    pulse_start(0);
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 6 && n < 1000) begin
      @(negedge clk);
      n++;
      if (ws_a && !prev) rises++;
      prev = ws_a;
    end
    check("r_bit5_reached", 72'(rises), 72'd6);
    rst = 1'b1;
    @(negedge clk);
    check("r_ws", 72'(ws_a), 72'd0);
    check("r_busy", 72'(busy_a), 72'd0);
    check("r_done", 72'(done_a), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start(0);
    get_frame(48, d, lat, bad, llo);
    check("r_replay_data", d, 72'h341256_000001);
    check("r_replay_timing", 72'(bad), 72'd0);
    @(negedge clk);

    // Out-of-range write ignored on a three-pixel chain
    sel = 1'b1;
    write_px(1, 0, 24'hAABBCC);
    write_px(1, 1, 24'h010203);
    write_px(1, 2, 24'h800000);
    write_px(1, 3, 24'hFFFFFF);
    pulse_start(1);
    get_frame(72, d, lat, bad, llo);
    check("b_latency", 72'(lat), 72'd2);
    check("b_data", d, 72'hBBAACC_020103_008000);
    check("b_timing", 72'(bad), 72'd0);
    check("b_latch_len", 72'(llo), 72'(T_LONG + T_RES));
    @(negedge clk);
    check("b_busy_fall", 72'(busy_s), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
